ro_process_monitor: RTL and testbench

//  Controls and measures an on-die ring oscillator (RO) built from INVx1/BUF standard cells. Sits directly downstream of the RO.
//  - Enables the RO and waits for it to settle.
//  - Counts rising edges of the RO output over a fixed window of clk cycles.
//  - Returns the count as a process/voltage/temperature speed indicator to the CSR block.

---
 rtl/pmon_pkg.sv | 24 ++
 rtl/pmon_sync.sv | 34 +++
 rtl/ro_process_monitor.sv | 143 ++++++++++++++
 tb/tb_ro_process_monitor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmon_pkg.sv
// Shared types and default constants for the ring-oscillator process monitor.
// The optional min/max tracking feature is controlled by PMON_MINMAX_EN in
// ro_process_monitor; nothing in this package depends on it.
package pmon_pkg;

  // Measurement sequence: enable and settle the ring, count edges, report.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } pmon_state_e;

  localparam int PMON_SETTLE_CYC  = 16;
  localparam int PMON_CNT_W       = 16;
  localparam int PMON_SYNC_STAGES = 2;
  localparam int PMON_WINDOW_W    = 12;

  // Larger of two integers, used to size the shared settle/window timer.
  function automatic int pmon_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pmon_sync.sv
// Synchronizer and rising-edge detector for the asynchronous ring-oscillator
// output. ro_i is brought into the clk domain through SYNC_STAGES flops; a
// history flop behind the last stage yields a registered one-cycle pulse per
// 0->1 transition. Total lag from ro_i to edge_o is SYNC_STAGES+1 cycles.
module pmon_sync
  import pmon_pkg::*;
#(
  parameter int SYNC_STAGES = PMON_SYNC_STAGES  // legal range 2..4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift ro_i through the synchronizer and flag each synchronized rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // pre-edge value, so the chain advances exactly one stage per clock.
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_o <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

// File: rtl/ro_process_monitor.sv
// Ring-oscillator process monitor: enables the RO, lets it settle for
// SETTLE_CYC clocks, counts synchronized rising edges over a programmable
// window of clk cycles and reports a saturating count with an overflow flag.
// A single down-counter times both the settle phase and the window.
// Optional feature: define PMON_MINMAX_EN to add running min_o/max_o of the
// reported counts, cleared by clr_minmax_i.
module ro_process_monitor
  import pmon_pkg::*;
#(
  parameter int SYNC_STAGES = PMON_SYNC_STAGES,
  parameter int SETTLE_CYC  = PMON_SETTLE_CYC,
  parameter int WINDOW_W    = PMON_WINDOW_W,
  parameter int CNT_W       = PMON_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [WINDOW_W-1:0] window_i,
  input  logic                ro_i,
`ifdef PMON_MINMAX_EN
  input  logic                clr_minmax_i,
  output logic [CNT_W-1:0]    min_o,
  output logic [CNT_W-1:0]    max_o,
`endif
  output logic                ro_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                ovf_o
);

  // The timer must hold both SETTLE_CYC-1 and the largest window minus one.
  localparam int TMR_W = pmon_max(WINDOW_W, $clog2(SETTLE_CYC) + 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  pmon_state_e         state_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [WINDOW_W-1:0] win_m1_q;   // window length minus one, captured on accept
  logic [WINDOW_W-1:0] win_m1;
  logic [CNT_W-1:0]    cnt_q;      // saturating edge counter
  logic                ovf_q;      // sticky saturation flag for this run
  logic                ro_edge;
  logic                accept;
  logic                tmr_zero;

  pmon_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_i   (ro_i),
    .edge_o (ro_edge)
  );

  // A zero window is treated as a one-cycle window, so it loads as zero here.
  assign win_m1   = (window_i == '0) ? '0 : window_i - WINDOW_W'(1);
  // Starts are honoured when idle and in the DONE cycle (back-to-back runs).
  assign accept   = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign tmr_zero = (tmr_q == '0);

  // Measurement FSM with shared timer, edge counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      win_m1_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ro_en_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      count_o  <= '0;
      ovf_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // Acceptance is handled below, shared with the DONE cycle.
        end

        SETTLE: begin
          // Edges are ignored here; the detector history still tracks ro_i.
          if (tmr_zero) begin
            tmr_q   <= TMR_W'(win_m1_q);
            state_q <= COUNT;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        COUNT: begin
          if (ro_edge) begin
            if (cnt_q == '1) ovf_q <= 1'b1;
            else             cnt_q <= cnt_q + CNT_W'(1);
          end
          if (tmr_zero) state_q <= DONE;
          else          tmr_q   <= tmr_q - TMR_W'(1);
        end

        DONE: begin
          done_o  <= 1'b1;
          count_o <= cnt_q;
          ovf_o   <= ovf_q;
          ro_en_o <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase

      // A new run overrides the IDLE return above; being later in the block,
      // these assignments win, so busy/ro_en never drop on a back-to-back start.
      if (accept) begin
        win_m1_q <= win_m1;
        tmr_q    <= SETTLE_LOAD;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        ro_en_o  <= 1'b1;
        busy_o   <= 1'b1;
        state_q  <= SETTLE;
      end
    end
  end

`ifdef PMON_MINMAX_EN
  // Running extremes of reported counts; a clear beats a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_o <= '1;
      max_o <= '0;
    end else if (clr_minmax_i) begin
      min_o <= '1;
      max_o <= '0;
    end else if (state_q == DONE) begin
      if (cnt_q < min_o) min_o <= cnt_q;
      if (cnt_q > max_o) max_o <= cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_ro_process_monitor.sv
// Self-checking bench for ro_process_monitor. Two instances share all inputs:
// one with defaults (CNT_W=16, SYNC_STAGES=2) and one narrow (CNT_W=4,
// SYNC_STAGES=3) to exercise saturation. The RO is driven from the bench and
// every rising edge is logged with its cycle number; expected counts come from
// the window rule: an edge counts if its detection (lag SYNC_STAGES+1) lands in
// the window of clk cycles following the settle period.
module tb_ro_process_monitor;

  localparam int SETTLE = 16;
  localparam int WW     = 12;
  localparam int SYNC_A = 2;
  localparam int SYNC_B = 3;
  localparam int CNTW_A = 16;
  localparam int CNTW_B = 4;
  localparam int MAX_A  = (1 << CNTW_A) - 1;
  localparam int MAX_B  = (1 << CNTW_B) - 1;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic [WW-1:0]     window_i;
  logic              ro_i;
  logic              ro_en_a, busy_a, done_a, ovf_a;
  logic [CNTW_A-1:0] count_a;
  logic              ro_en_b, busy_b, done_b, ovf_b;
  logic [CNTW_B-1:0] count_b;
`ifdef PMON_MINMAX_EN
  logic              clr_minmax_i;
  logic [CNTW_A-1:0] min_a, max_a;
  logic [CNTW_B-1:0] min_b, max_b;
`endif

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int rises[$];
  int ro_hi  = 2;
  int ro_lo  = 2;
  bit ro_rand = 1'b0;
  int mn_model = MAX_A;
  int mx_model = 0;

  ro_process_monitor #(
    .SYNC_STAGES (SYNC_A),
    .SETTLE_CYC  (SETTLE),
    .WINDOW_W    (WW),
    .CNT_W       (CNTW_A)
  ) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .window_i     (window_i),
    .ro_i         (ro_i),
`ifdef PMON_MINMAX_EN
    .clr_minmax_i (clr_minmax_i),
    .min_o        (min_a),
    .max_o        (max_a),
`endif
    .ro_en_o      (ro_en_a),
    .busy_o       (busy_a),
    .done_o       (done_a),
    .count_o      (count_a),
    .ovf_o        (ovf_a)
  );

  ro_process_monitor #(
    .SYNC_STAGES (SYNC_B),
    .SETTLE_CYC  (SETTLE),
    .WINDOW_W    (WW),
    .CNT_W       (CNTW_B)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .window_i     (window_i),
    .ro_i         (ro_i),
`ifdef PMON_MINMAX_EN
    .clr_minmax_i (clr_minmax_i),
    .min_o        (min_b),
    .max_o        (max_b),
`endif
    .ro_en_o      (ro_en_b),
    .busy_o       (busy_b),
    .done_o       (done_b),
    .count_o      (count_b),
    .ovf_o        (ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle k is the interval following the k-th rising clock edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Ring-oscillator stand-in: changes on falling edges, logs each rising edge.
  initial begin : ro_gen
    int left;
    int cur_hi;
    ro_i   = 1'b0;
    left   = 1;
    cur_hi = 1;
    forever begin
      @(negedge clk);
      left--;
      if (left <= 0) begin
        ro_i = ~ro_i;
        if (ro_i) rises.push_back(cyc);
        if (ro_rand) begin
          if (ro_i) begin
            cur_hi = $urandom_range(3, 1);
            left   = cur_hi;
          end else begin
            left = $urandom_range(3, (cur_hi == 1) ? 2 : 1);
          end
        end else begin
          left = ro_i ? ro_hi : ro_lo;
        end
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raw number of RO rising edges whose detection falls inside the window of a
  // run started (start_i driven) in cycle a.
  function automatic int exp_cnt(input int a, input int w, input int lag);
    int n = 0;
    foreach (rises[i])
      if ((rises[i] + lag >= a + SETTLE + 1) && (rises[i] + lag <= a + SETTLE + w)) n++;
    return n;
  endfunction

  task automatic launch(input int win, output int a);
    @(negedge clk);
    start_i  = 1'b1;
    window_i = WW'(win);
    a        = cyc;
  endtask

  // Follow a run to its done_o pulse. hold keeps start_i high so the DONE cycle
  // accepts a new run with window next_win; poke pulses start_i at cycle a+poke.
  task automatic expect_done(input int a, input int win, input bit hold,
                             input int next_win, input int poke, output int a_next);
    int w, target, raw_a, raw_b, ea, eb;
    bit early, bad_busy;
    early    = 1'b0;
    bad_busy = 1'b0;
    w        = (win == 0) ? 1 : win;
    target   = a + SETTLE + w + 2;
    a_next   = -1;
    while (cyc < target) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (poke != 0 && cyc == a + poke) begin
        start_i  = 1'b1;
        window_i = WW'($urandom_range(4095, 0));
      end
      if (hold && cyc == target - 1) window_i = WW'(next_win);
      if (cyc < target) begin
        if (done_a || done_b) early = 1'b1;
        if (!(busy_a && ro_en_a && busy_b && ro_en_b)) bad_busy = 1'b1;
      end
    end
    raw_a = exp_cnt(a, w, SYNC_A + 1);
    raw_b = exp_cnt(a, w, SYNC_B + 1);
    ea    = (raw_a > MAX_A) ? MAX_A : raw_a;
    eb    = (raw_b > MAX_B) ? MAX_B : raw_b;
    check("no_early_done", early, 0);
    check("busy_ro_en_held", bad_busy, 0);
    check("done_a", done_a, 1);
    check("done_b", done_b, 1);
    check("count_a", count_a, ea);
    check("ovf_a", ovf_a, (raw_a > MAX_A) ? 1 : 0);
    check("count_b", count_b, eb);
    check("ovf_b", ovf_b, (raw_b > MAX_B) ? 1 : 0);
    check("busy_at_done", {busy_a, ro_en_a}, hold ? 3 : 0);
`ifdef PMON_MINMAX_EN
    if (ea < mn_model) mn_model = ea;
    if (ea > mx_model) mx_model = ea;
    check("min_a", min_a, mn_model);
    check("max_a", max_a, mx_model);
`endif
    if (hold) begin
      start_i = 1'b0;
      a_next  = target - 1;
    end else begin
      @(negedge clk);
      check("done_one_cycle", done_a, 0);
      check("idle_after_done", {busy_a, ro_en_a, busy_b, ro_en_b}, 0);
    end
  endtask

  initial begin : stim
    int a, a2, dummy, win;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    window_i = '0;
`ifdef PMON_MINMAX_EN
    clr_minmax_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_flags_a", {ro_en_a, busy_a, done_a, ovf_a}, 0);
    check("reset_count_a", count_a, 0);
    check("reset_all_b", {ro_en_b, busy_b, done_b, ovf_b, count_b}, 0);
`ifdef PMON_MINMAX_EN
    check("reset_min_a", min_a, MAX_A);
    check("reset_max_a", max_a, 0);
`endif
    rst_n = 1'b1;

    // Idle: the RO toggles but nothing is started.
    for (int i = 0; i < 6; i++) begin
      repeat (8) @(negedge clk);
      check("idle_quiet", {ro_en_a, busy_a, done_a, ovf_a, count_a,
                           ro_en_b, busy_b, done_b, ovf_b, count_b}, 0);
    end

    // RO at clk/4, window 100: done 118 cycles after start, about 25 edges.
    ro_hi = 2; ro_lo = 2;
    launch(100, a);
    expect_done(a, 100, 1'b0, 0, 0, dummy);
    check("clk4_count_range", (count_a >= 24 && count_a <= 26), 1);

    // RO at clk/3, window 300: narrow counter saturates.
    ro_hi = 1; ro_lo = 2;
    launch(300, a);
    expect_done(a, 300, 1'b0, 0, 0, dummy);
    check("sat_count_b", count_b, MAX_B);
    check("sat_ovf_b", ovf_b, 1);

    // Start during COUNT is ignored, then a back-to-back pair.
    ro_rand = 1'b1;
    launch(60, a);
    expect_done(a, 60, 1'b0, 0, SETTLE + 20, dummy);
    launch(40, a);
    expect_done(a, 40, 1'b1, 50, 0, a2);
    expect_done(a2, 50, 1'b0, 0, 0, dummy);

    // Reset in the middle of COUNT.
    launch(200, a);
    @(negedge clk);
    start_i = 1'b0;
    repeat (SETTLE + 30) @(negedge clk);
    check("pre_reset_busy", {busy_a, ro_en_a}, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_a", {ro_en_a, busy_a, done_a, ovf_a, count_a}, 0);
    check("async_reset_b", {ro_en_b, busy_b, done_b, ovf_b, count_b}, 0);
    mn_model = MAX_A;
    mx_model = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", {ro_en_a, busy_a, done_a}, 0);
    launch(80, a);
    expect_done(a, 80, 1'b0, 0, 0, dummy);

    // Zero window behaves as a single-cycle window.
    launch(0, a);
    expect_done(a, 0, 1'b0, 0, 0, dummy);
    check("win0_le1", (count_a <= 1), 1);

    // Randomized runs with mixed RO behaviour.
    for (int i = 0; i < 8; i++) begin
      ro_rand = ($urandom_range(1, 0) == 1);
      ro_hi   = $urandom_range(4, 1);
      ro_lo   = $urandom_range(4, (ro_hi == 1) ? 2 : 1);
      win     = $urandom_range(150, 0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      launch(win, a);
      expect_done(a, win, 1'b0, 0, 0, dummy);
    end

`ifdef PMON_MINMAX_EN
    // Clear, then three runs of roughly 20, 35 and 10 edges.
    @(negedge clk);
    clr_minmax_i = 1'b1;
    @(negedge clk);
    clr_minmax_i = 1'b0;
    mn_model = MAX_A;
    mx_model = 0;
    check("clr_min_a", min_a, MAX_A);
    check("clr_max_a", max_a, 0);
    ro_rand = 1'b0; ro_hi = 2; ro_lo = 2;
    launch(80, a);
    expect_done(a, 80, 1'b0, 0, 0, dummy);
    launch(140, a);
    expect_done(a, 140, 1'b0, 0, 0, dummy);
    launch(40, a);
    expect_done(a, 40, 1'b0, 0, 0, dummy);
    @(negedge clk);
    clr_minmax_i = 1'b1;
    @(negedge clk);
    clr_minmax_i = 1'b0;
    check("clr2_min_a", min_a, MAX_A);
    check("clr2_max_a", max_a, 0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
